// File: rtl/snail_fsm_moore_000.sv
// Moore "snail" detector: Q is high while the last three sampled D bits were 0.
// Optional hit counter of DETECT entries is enabled by defining SNAIL_HIT_CNT_EN.
module snail_fsm_moore_000 #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             _rst,
    input  logic             D,
    output logic             Q
`ifdef SNAIL_HIT_CNT_EN
    ,
    output logic [CNT_W-1:0] hit_cnt
`endif
);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        Z1     = 2'b01,
        Z2     = 2'b10,
        DETECT = 2'b11
    } state_t;

    state_t      state;
    state_t      next_state;
    logic [63:0] txstate;

    always_comb begin
        next_state = IDLE;
        if (!D) begin
            case (state)
                IDLE:    next_state = Z1;
                Z1:      next_state = Z2;
                Z2:      next_state = DETECT;
                DETECT:  next_state = DETECT;
                default: next_state = IDLE;
            endcase
        end
    end

    // Q is registered from the next state, so it always equals (state == DETECT).
    always_ff @(posedge clk) begin
        if (_rst) begin
            state <= IDLE;
            Q     <= 1'b0;
`ifdef SNAIL_HIT_CNT_EN
            hit_cnt <= '0;
`endif
        end else begin
            state <= next_state;
            Q     <= (next_state == DETECT);
`ifdef SNAIL_HIT_CNT_EN
            if (next_state == DETECT && state != DETECT)
                hit_cnt <= hit_cnt + 1'b1;
`endif
        end
    end

    // Waveform aid: ASCII state name, right-justified and zero-padded.
    always_comb begin
        txstate = 64'd0;
        case (state)
            IDLE:    txstate = {32'd0, "IDLE"};
            Z1:      txstate = {48'd0, "Z1"};
            Z2:      txstate = {48'd0, "Z2"};
            DETECT:  txstate = {16'd0, "DETECT"};
            default: txstate = 64'd0;
        endcase
    end

endmodule

// File: tb/tb_snail_fsm_moore_000.sv
// Randomized and directed bench for snail_fsm_moore_000 against a trailing-zero-count model.
module tb_snail_fsm_moore_000;

`ifdef SNAIL_HIT_CNT_EN
    localparam int CNT_W = 2;
`else
    localparam int CNT_W = 8;
`endif

    logic clk;
    logic _rst;
    logic D;
    logic Q;
`ifdef SNAIL_HIT_CNT_EN
    logic [CNT_W-1:0] hit_cnt;
`endif

    int checks   = 0;
    int failures = 0;

    // model state: number of consecutive trailing zeros since reset / last 1
    int zrun    = 0;
    int hits    = 0;
    bit enabled = 0;

    snail_fsm_moore_000 #(.CNT_W(CNT_W)) dut (
        .clk  (clk),
        ._rst (_rst),
        .D    (D),
        .Q    (Q)
`ifdef SNAIL_HIT_CNT_EN
        ,
        .hit_cnt (hit_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] name_of(input int z);
        if (z == 0) return {32'd0, "IDLE"};
        if (z == 1) return {48'd0, "Z1"};
        if (z == 2) return {48'd0, "Z2"};
        return {16'd0, "DETECT"};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model update on each edge, then compare once outputs have settled.
    always @(posedge clk) begin
        logic r, d;
        r = _rst;
        d = D;
        if (r) begin
            zrun    = 0;
            hits    = 0;
            enabled = 1;
        end else if (enabled) begin
            if (d) zrun = 0;
            else begin
                zrun = zrun + 1;
                if (zrun == 3) hits = (hits + 1) % (1 << CNT_W);
            end
        end
        #1;
        if (enabled) begin
            chk("model_q", {63'd0, Q}, {63'd0, (zrun >= 3)});
            chk("model_txstate", dut.txstate, name_of(zrun));
`ifdef SNAIL_HIT_CNT_EN
            chk("model_hit_cnt", {{(64-CNT_W){1'b0}}, hit_cnt}, 64'(hits));
`endif
        end
    end

    task automatic step(input logic r, input logic d);
        @(negedge clk);
        _rst = r;
        D    = d;
        @(posedge clk);
        #2;
    endtask

    task automatic step_q(input logic r, input logic d, input logic expq, input string nm);
        step(r, d);
        chk(nm, {63'd0, Q}, {63'd0, expq});
    endtask

    initial begin
        _rst = 1'b1;
        D    = 1'b0;

        // reset, then a plain run of zeros
        step_q(1, 0, 0, "lit_reset_q");
        chk("lit_reset_txstate", dut.txstate, {32'd0, "IDLE"});
        step_q(0, 0, 0, "lit_z1_q");
        chk("lit_z1_txstate", dut.txstate, {48'd0, "Z1"});
        step_q(0, 0, 0, "lit_z2_q");
        step_q(0, 0, 1, "lit_detect_q");
        chk("lit_detect_txstate", dut.txstate, {16'd0, "DETECT"});

        // 0,0,1,0,0,0 from IDLE
        step_q(0, 1, 0, "lit_break_q");
        step_q(0, 0, 0, "lit_s1");
        step_q(0, 0, 0, "lit_s2");
        step_q(0, 1, 0, "lit_s3");
        step_q(0, 0, 0, "lit_s4");
        step_q(0, 0, 0, "lit_s5");
        step_q(0, 0, 1, "lit_s6");

        // overlap in DETECT, then a 1
        for (int i = 0; i < 4; i++) step_q(0, 0, 1, "lit_overlap_q");
        step_q(0, 1, 0, "lit_exit_q");
        chk("lit_exit_txstate", dut.txstate, {32'd0, "IDLE"});

        // reset while in DETECT
        step(0, 0); step(0, 0); step_q(0, 0, 1, "lit_pre_rst_q");
        step_q(1, 0, 0, "lit_mid_rst_q");
        step_q(0, 0, 0, "lit_post_rst1");
        step_q(0, 0, 0, "lit_post_rst2");
        step_q(0, 0, 1, "lit_post_rst3");

        // random stream
        step(1, 0);
        for (int i = 0; i < 70; i++) step(($urandom_range(0, 9) == 0), ($urandom_range(0, 2) == 0));

`ifdef SNAIL_HIT_CNT_EN
        begin
            logic [CNT_W-1:0] exp_seq [5];
            exp_seq[0] = 2'd1; exp_seq[1] = 2'd2; exp_seq[2] = 2'd3;
            exp_seq[3] = 2'd0; exp_seq[4] = 2'd1;
            step(1, 0);
            chk("lit_hit_reset", {{(64-CNT_W){1'b0}}, hit_cnt}, 64'd0);
            for (int r = 0; r < 5; r++) begin
                step(0, 0); step(0, 0); step(0, 0);
                step(0, 1);
                chk("lit_hit_wrap", {{(64-CNT_W){1'b0}}, hit_cnt}, {{(64-CNT_W){1'b0}}, exp_seq[r]});
            end
        end
`endif

        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/snail_fsm_moore_000.md
Name: snail_fsm_moore_000

Overview:
- Moore-type "snail" sequence detector: serial bit stream D is sampled on each rising clk edge.
- Output Q asserts while the last three sampled bits were 0,0,0; overlapping occurrences count.
- Leaf block used as a lab/teaching FSM.
- Provides an ASCII state-name debug signal for waveform viewing.

Parameters:
- CNT_W, 8, width of the optional hit counter; used only when SNAIL_HIT_CNT_EN is defined.

Ports:
- clk  input  1  rising-edge clock, sole clock domain
- _rst  input  1  reset; synchronous, active-high (1 = reset on the next rising clk edge)
- D  input  1  serial data bit, sampled at rising clk
- Q  output  1  detect flag; Moore output, a function of the current state only
- hit_cnt  output  CNT_W  count of entries into DETECT; present only with SNAIL_HIT_CNT_EN

Behaviour:
- One clock; reset is synchronous and active-high, applied through port _rst.
- On a rising clk edge with _rst=1: state <= IDLE and Q=0. D is ignored that cycle.
- Reset mid-stream discards all zero history; counting restarts from IDLE.
- States, 2-bit encoding:
  - IDLE=00: no trailing zero
  - Z1=01: one trailing zero
  - Z2=10: two trailing zeros
  - DETECT=11: three or more trailing zeros
- Transitions on a rising clk edge with _rst=0:
  - D=1 from any state -> IDLE
  - D=0: IDLE->Z1, Z1->Z2, Z2->DETECT, DETECT->DETECT
- Q=1 iff state==DETECT, otherwise 0.
  - Q is decoded from the state register only, with no combinational path from D.
  - Latency: Q rises in the cycle after the clk edge that samples the third consecutive 0.
  - Q falls in the cycle after the edge that samples a 1.
- Unreachable/illegal encodings cannot occur with a 2-bit encoding. The default branch still goes to IDLE.
- Internal debug signal txstate, 64 bits, must exist under exactly that name. It holds the ASCII name of the current state, right-justified and zero-padded: "IDLE", "Z1", "Z2", "DETECT".
  - txstate is combinational from state and is not synthesised logic of interest.
- D changing between edges has no effect until the next rising edge.

Optional Feature:
- Macro SNAIL_HIT_CNT_EN.
- When defined:
  - Adds output hit_cnt[CNT_W-1:0], reset to 0 by _rst.
  - hit_cnt increments by 1 on each clk edge where next_state==DETECT and the current state!=DETECT, i.e. once per run of zeros of length >=3.
  - hit_cnt wraps from 2^CNT_W-1 to 0.
- When undefined:
  - No hit_cnt port and no counter logic.
  - All other behaviour is identical.

Test Plan:
- Hold _rst=1 for one clk edge with D=0 -> state IDLE, Q=0, txstate="IDLE". Release _rst and keep D=0 -> states Z1, Z2, DETECT on successive edges; Q=1 from the third edge onward.
- D sequence 0,0,1,0,0,0 -> Q stays 0 through the first 5 edges and becomes 1 after the 6th. The 1 resets the zero count.
- In DETECT, D=0,0,0,0 -> Q held at 1 continuously (overlap). Then D=1 -> Q=0 one edge later, state IDLE.
- While in DETECT, assert _rst=1 with D=0 for one edge -> state IDLE, Q=0 at that edge. Then D=0,0 -> Q still 0; one more 0 -> Q=1.
- Random D for 70 clk cycles, with a scoreboard tracking the last three sampled bits -> Q==(last3==000) at every cycle after reset, and txstate always matches state.
- With SNAIL_HIT_CNT_EN, CNT_W=2: five separate runs of "000" each followed by a 1 -> hit_cnt sequence 1,2,3,0,1 (wrap verified). Without the macro the bench compiles without hit_cnt.
